// File: rtl/trace_pkg.sv
// Shared types for the commit-trace checker.
// One trace entry is {pc, rd, wdata}.
package trace_pkg;

  localparam int TRACE_ENTRY_W = 69;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } trace_entry_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE,
    HALT
  } checker_state_e;

endpackage

// File: rtl/trace_commit_fifo.sv
// Multi-push, single-pop circular buffer of trace entries.
// Pushed entries arrive already compacted into slots 0..i_push_cnt-1.
module trace_commit_fifo
  import trace_pkg::*;
#(
  parameter  int LANES = 2,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1,
  localparam int PC_W  = $clog2(LANES + 1)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [PC_W-1:0]         i_push_cnt,
  input  trace_entry_t [LANES-1:0] i_push_data,
  input  logic                    i_pop,
  output trace_entry_t            o_head,
  output logic [CNT_W-1:0]        o_count,
  output logic [CNT_W-1:0]        o_free
);

  trace_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(i_push_cnt)) begin
        r_mem[r_wr + PTR_W'(i)] <= i_push_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= r_wr + PTR_W'(i_push_cnt);
      r_rd  <= r_rd + PTR_W'(i_pop);
      r_cnt <= r_cnt + CNT_W'(i_push_cnt)
             - CNT_W'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;
  assign o_free  = CNT_W'(DEPTH) - r_cnt;

endmodule

// File: rtl/trace_commit_checker.sv
// Compares in-order core commits against a reference trace stream,
// tracking mismatches, overflow and end-of-test.
module trace_commit_checker
  import trace_pkg::*;
#(
  parameter int          LANES       = 2,
  parameter int          DEPTH       = 8,
  parameter logic [31:0] END_PC      = 32'hbfc00100,
  parameter int          ERR_W       = 8,
  parameter int          STOP_ON_ERR = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [LANES-1:0]     commit_valid,
  input  logic [LANES*32-1:0]  commit_pc,
  input  logic [LANES*5-1:0]   commit_rd,
  input  logic [LANES*32-1:0]  commit_wdata,
  input  logic                 ref_valid,
  input  logic [31:0]          ref_pc,
  input  logic [4:0]           ref_rd,
  input  logic [31:0]          ref_wdata,
  output logic                 ref_ready,
  output logic                 mismatch,
  output logic [ERR_W-1:0]     err_count,
  output logic                 first_err_valid,
  output trace_entry_t         first_err_dut,
  output trace_entry_t         first_err_ref,
  output logic                 overflow,
  output logic                 done,
  output logic                 pass
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PC_W  = $clog2(LANES + 1);

  checker_state_e r_state, w_nstate;

  trace_entry_t [LANES-1:0] w_push_data;
  logic [PC_W-1:0]  w_push_cnt;
  logic [CNT_W-1:0] w_count, w_free;
  trace_entry_t     w_head, w_ref, w_lane;
  logic             w_drop, w_end;
  logic             w_active, w_pop, w_mis;

  logic             r_mis, r_fv, r_ovf;
  logic [ERR_W-1:0] r_err;
  trace_entry_t     r_fd, r_fr;

  assign w_active  = (r_state == RUN) || (r_state == DRAIN);
  assign w_ref     = '{pc: ref_pc, rd: ref_rd, wdata: ref_wdata};
  assign ref_ready = w_active && (w_count != '0) && ref_valid;
  assign w_pop     = ref_ready;
  assign w_mis     = w_pop && (w_head != w_ref);

  // Compact rd!=0 lanes up to and including an END_PC lane.
  always_comb begin
    int   n;
    logic stop;
    n           = 0;
    stop        = 1'b0;
    w_push_data = '0;
    w_drop      = 1'b0;
    w_lane      = '0;
    for (int i = 0; i < LANES; i++) begin
      w_lane = '{pc:    commit_pc[i*32 +: 32],
                 rd:    commit_rd[i*5 +: 5],
                 wdata: commit_wdata[i*32 +: 32]};
      if (r_state == RUN && commit_valid[i] && !stop) begin
        stop = (w_lane.pc == END_PC);
        if (w_lane.rd != '0) begin
          if (n < int'(w_free)) begin
            for (int j = 0; j < LANES; j++) begin
              if (j == n) w_push_data[j] = w_lane;
            end
            n = n + 1;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
    end
    w_end      = stop;
    w_push_cnt = PC_W'(n);
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      RUN: begin
        if (w_drop)
          w_nstate = HALT;
        else if (w_mis && STOP_ON_ERR != 0)
          w_nstate = HALT;
        else if (w_end)
          w_nstate = DRAIN;
      end
      DRAIN: begin
        if (w_mis && STOP_ON_ERR != 0)
          w_nstate = HALT;
        else if (w_count == CNT_W'(w_pop))
          w_nstate = DONE;
      end
      default: w_nstate = r_state;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= RUN;
      r_mis   <= 1'b0;
      r_err   <= '0;
      r_fv    <= 1'b0;
      r_fd    <= '0;
      r_fr    <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_mis   <= w_mis;
      if (w_mis && r_err != '1)
        r_err <= r_err + ERR_W'(1);
      if (w_mis && !r_fv) begin
        r_fv <= 1'b1;
        r_fd <= w_head;
        r_fr <= w_ref;
      end
      if (w_drop)
        r_ovf <= 1'b1;
    end
  end

  trace_commit_fifo #(
    .LANES (LANES),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .i_push_cnt  (w_push_cnt),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_free      (w_free)
  );

  assign mismatch        = r_mis;
  assign err_count       = r_err;
  assign first_err_valid = r_fv;
  assign first_err_dut   = r_fd;
  assign first_err_ref   = r_fr;
  assign overflow        = r_ovf;
  assign done            = (r_state == DONE);
  assign pass            = done && (r_err == '0) && !r_ovf;

endmodule

// File: tb/tb_trace_commit_checker.sv
// Directed bench for trace_commit_checker with a queue-based
// reference model checked on every falling edge.
module tb_trace_commit_checker;
  import trace_pkg::*;

  localparam int          DEPTH  = 8;
  localparam logic [31:0] END_PC = 32'hbfc00100;

  logic         clk;
  logic         resetn;
  logic [1:0]   commit_valid;
  logic [63:0]  commit_pc;
  logic [9:0]   commit_rd;
  logic [63:0]  commit_wdata;
  logic         ref_valid;
  logic [31:0]  ref_pc;
  logic [4:0]   ref_rd;
  logic [31:0]  ref_wdata;
  logic         ref_ready;
  logic         mismatch;
  logic [7:0]   err_count;
  logic         first_err_valid;
  trace_entry_t first_err_dut;
  trace_entry_t first_err_ref;
  logic         overflow;
  logic         done;
  logic         pass;

  int n_tests = 0;
  int n_fail  = 0;

  trace_commit_checker #(
    .LANES       (2),
    .DEPTH       (DEPTH),
    .END_PC      (END_PC),
    .ERR_W       (8),
    .STOP_ON_ERR (0)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .commit_valid    (commit_valid),
    .commit_pc       (commit_pc),
    .commit_rd       (commit_rd),
    .commit_wdata    (commit_wdata),
    .ref_valid       (ref_valid),
    .ref_pc          (ref_pc),
    .ref_rd          (ref_rd),
    .ref_wdata       (ref_wdata),
    .ref_ready       (ref_ready),
    .mismatch        (mismatch),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_dut   (first_err_dut),
    .first_err_ref   (first_err_ref),
    .overflow        (overflow),
    .done            (done),
    .pass            (pass)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [68:0] act,
                     input logic [68:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-order queue of expected commits.
  trace_entry_t mq[$];
  bit           m_drain, m_halt, m_done, m_mis, m_fv, m_ovf;
  int           m_err;
  trace_entry_t m_fd, m_fr;

  function automatic bit m_ready();
    return !m_halt && !m_done && mq.size() > 0 && ref_valid;
  endfunction

  function automatic trace_entry_t lane(input int i);
    trace_entry_t e;
    e.pc    = commit_pc[i*32 +: 32];
    e.rd    = commit_rd[i*5 +: 5];
    e.wdata = commit_wdata[i*32 +: 32];
    return e;
  endfunction

  task automatic m_clear();
    mq.delete();
    m_drain = 0; m_halt = 0; m_done = 0; m_mis = 0;
    m_fv = 0; m_ovf = 0; m_err = 0;
    m_fd = '0; m_fr = '0;
  endtask

  task automatic m_advance();
    int           occ, acc;
    bit           pop, seen_end, drop;
    trace_entry_t h, r, e;
    occ = mq.size();
    pop = m_ready();
    r   = '{pc: ref_pc, rd: ref_rd, wdata: ref_wdata};
    m_mis = 0;
    if (pop) begin
      h = mq.pop_front();
      if (h != r) begin
        m_mis = 1;
        if (m_err < 255) m_err++;
        if (!m_fv) begin
          m_fv = 1; m_fd = h; m_fr = r;
        end
      end
    end
    if (!m_halt && !m_done && !m_drain) begin
      acc = 0; seen_end = 0; drop = 0;
      for (int i = 0; i < 2; i++) begin
        if (commit_valid[i] && !seen_end) begin
          e = lane(i);
          if (e.pc == END_PC) seen_end = 1;
          if (e.rd != 0) begin
            if (occ + acc < DEPTH) begin
              mq.push_back(e);
              acc++;
            end else begin
              drop = 1;
            end
          end
        end
      end
      if (drop) begin
        m_ovf = 1; m_halt = 1;
      end else if (seen_end) begin
        m_drain = 1;
      end
    end else if (m_drain && !m_halt && mq.size() == 0) begin
      m_done = 1;
    end
  endtask

  // Compare process: outputs vs model, then model absorbs this cycle's inputs.
  initial begin
    m_clear();
    forever begin
      @(negedge clk);
      if (!resetn) m_clear();
      chk("ref_ready", ref_ready, m_ready());
      chk("mismatch", mismatch, m_mis);
      chk("err_count", err_count, m_err[7:0]);
      chk("first_err_valid", first_err_valid, m_fv);
      chk("first_err_dut", first_err_dut, m_fd);
      chk("first_err_ref", first_err_ref, m_fr);
      chk("overflow", overflow, m_ovf);
      chk("done", done, m_done);
      chk("pass", pass, m_done && m_err == 0 && !m_ovf);
      if (resetn) m_advance();
    end
  end

  function automatic trace_entry_t te(input logic [31:0] pc,
                                      input logic [4:0] rd,
                                      input logic [31:0] wd);
    trace_entry_t e;
    e.pc = pc; e.rd = rd; e.wdata = wd;
    return e;
  endfunction

  task automatic commit2(input logic [1:0] v, input trace_entry_t a,
                         input trace_entry_t b);
    commit_valid = v;
    commit_pc    = {b.pc, a.pc};
    commit_rd    = {b.rd, a.rd};
    commit_wdata = {b.wdata, a.wdata};
    @(posedge clk); #1;
    commit_valid = '0;
  endtask

  task automatic send_ref(input trace_entry_t e);
    bit got;
    got = 0;
    ref_valid = 1'b1;
    ref_pc = e.pc; ref_rd = e.rd; ref_wdata = e.wdata;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ref_ready) begin
        got = 1;
        break;
      end
    end
    chk("ref_handshake", got, 1'b1);
    @(posedge clk); #1;
    ref_valid = 1'b0;
  endtask

  task automatic hold_ref(input trace_entry_t e, input int n);
    ref_valid = 1'b1;
    ref_pc = e.pc; ref_rd = e.rd; ref_wdata = e.wdata;
    repeat (n) begin
      @(negedge clk);
      chk("ref_not_ready", ref_ready, 1'b0);
    end
    @(posedge clk); #1;
    ref_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2 resetn = 1'b0;
    #4 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    resetn = 1'b0;
    commit_valid = '0; commit_pc = '0; commit_rd = '0; commit_wdata = '0;
    ref_valid = 1'b0; ref_pc = '0; ref_rd = '0; ref_wdata = '0;
    #2;
    chk("rst_ref_ready", ref_ready, 1'b0);
    chk("rst_err_count", err_count, 8'd0);
    chk("rst_first_dut", first_err_dut, '0);
    chk("rst_done_pass", {done, pass, overflow}, 3'b000);
    #9 resetn = 1'b1;
    @(posedge clk); #1;

    // Two lanes in one cycle, matching references.
    commit2(2'b11, te(32'hbfc00000, 5'd1, 32'd1), te(32'hbfc00004, 5'd2, 32'd2));
    send_ref(te(32'hbfc00000, 5'd1, 32'd1));
    chk("t1_mis0", mismatch, 1'b0);
    send_ref(te(32'hbfc00004, 5'd2, 32'd2));
    chk("t1_err0", err_count, 8'd0);

    // rd==0 lane is skipped: one entry only.
    commit2(2'b11, te(32'hbfc00008, 5'd0, 32'd9), te(32'hbfc0000c, 5'd3, 32'd5));
    send_ref(te(32'hbfc0000c, 5'd3, 32'd5));
    hold_ref(te(32'hbfc00008, 5'd0, 32'd9), 3);

    // First mismatch captured, later ones do not overwrite.
    commit2(2'b01, te(32'hbfc00010, 5'd4, 32'd5), te(32'h0, 5'd0, 32'd0));
    send_ref(te(32'hbfc00010, 5'd4, 32'd6));
    chk("t3_mis_pulse", mismatch, 1'b1);
    chk("t3_err1", err_count, 8'd1);
    chk("t3_fd_wdata", first_err_dut.wdata, 32'd5);
    chk("t3_fr_wdata", first_err_ref.wdata, 32'd6);
    commit2(2'b01, te(32'hbfc00014, 5'd5, 32'd7), te(32'h0, 5'd0, 32'd0));
    send_ref(te(32'hbfc00014, 5'd5, 32'd8));
    chk("t3_err2", err_count, 8'd2);
    chk("t3_fd_keep", first_err_dut, te(32'hbfc00010, 5'd4, 32'd5));
    chk("t3_fr_keep", first_err_ref, te(32'hbfc00010, 5'd4, 32'd6));
    commit2(2'b01, te(32'hbfc00018, 5'd6, 32'd1), te(32'h0, 5'd0, 32'd0));
    send_ref(te(32'hbfc00018, 5'd7, 32'd1));
    chk("t3_err3", err_count, 8'd3);

    // Asynchronous reset mid-stream with a ref offered.
    commit2(2'b01, te(32'hbfc0001c, 5'd8, 32'd8), te(32'h0, 5'd0, 32'd0));
    ref_valid = 1'b1;
    ref_pc = 32'hbfc0001c; ref_rd = 5'd8; ref_wdata = 32'd8;
    #2 resetn = 1'b0;
    #1;
    chk("t4_err_rst", err_count, 8'd0);
    chk("t4_fv_rst", first_err_valid, 1'b0);
    chk("t4_fd_rst", first_err_dut, '0);
    chk("t4_rr_rst", ref_ready, 1'b0);
    @(posedge clk); #1;
    chk("t4_rr_hold", ref_ready, 1'b0);
    ref_valid = 1'b0;
    #3 resetn = 1'b1;
    @(posedge clk); #1;

    // Fresh stream ending on END_PC; later lanes and cycles ignored.
    commit2(2'b11, te(32'hbfc00000, 5'd1, 32'd1), te(32'hbfc00004, 5'd2, 32'd2));
    commit2(2'b11, te(END_PC, 5'd3, 32'd3), te(32'hbfc00104, 5'd4, 32'd4));
    commit2(2'b11, te(32'hbfc00108, 5'd5, 32'd5), te(32'hbfc0010c, 5'd6, 32'd6));
    send_ref(te(32'hbfc00000, 5'd1, 32'd1));
    send_ref(te(32'hbfc00004, 5'd2, 32'd2));
    chk("t5_not_done", done, 1'b0);
    send_ref(te(END_PC, 5'd3, 32'd3));
    chk("t5_done", done, 1'b1);
    chk("t5_pass", pass, 1'b1);
    hold_ref(te(32'hbfc00104, 5'd4, 32'd4), 3);
    chk("t5_done_stay", done, 1'b1);

    // Overflow: 2 commits/cycle, no refs, DEPTH=8.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      commit2(2'b11, te(32'h1000 + 32'(c * 8), 5'd1, 32'(c)),
                     te(32'h1004 + 32'(c * 8), 5'd2, 32'(c)));
    end
    chk("t6_no_ovf", overflow, 1'b0);
    commit2(2'b11, te(32'h1040, 5'd1, 32'd9), te(32'h1044, 5'd2, 32'd9));
    chk("t6_ovf", overflow, 1'b1);
    chk("t6_pass0", pass, 1'b0);
    hold_ref(te(32'h1000, 5'd1, 32'd0), 3);
    commit2(2'b11, te(END_PC, 5'd1, 32'd1), te(32'h0, 5'd0, 32'd0));
    repeat (3) @(posedge clk);
    #1;
    chk("t6_halt_done0", done, 1'b0);
    chk("t6_ovf_sticky", overflow, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
